// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: lane-count helper and burst-cycle typedefs used by
// the SRAM target and the CDC blocks.
package wishbone_pkg;

    typedef enum logic [2:0] {
        CtiClassic    = 3'b000,
        CtiConstAddr  = 3'b001,
        CtiIncrAddr   = 3'b010,
        CtiEndOfBurst = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BteLinear = 2'b00,
        BteWrap4  = 2'b01,
        BteWrap8  = 2'b10,
        BteWrap16 = 2'b11
    } bte_e;

    function automatic int unsigned sel_width(input int unsigned data_width,
                                              input int unsigned granularity);
        return data_width / granularity;
    endfunction

endpackage

// File: rtl/wishbone_sram_target_if.sv
// Wishbone B4 pipelined bus bundle; signal names follow the B4 datasheet.
interface wishbone_sram_target_if
    import wishbone_pkg::*;
#(
    parameter int unsigned AddressWidth = 16,
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned Granularity  = 8,
    parameter int unsigned TGDWidth     = 1
);
    localparam int unsigned SelWidth = sel_width(DataWidth, Granularity);

    logic                    CYC;
    logic                    STB;
    logic                    WE;
    logic [AddressWidth-1:0] ADDR;
    logic [SelWidth-1:0]     SEL;
    logic [DataWidth-1:0]    DAT_ToTarget;
    logic [TGDWidth-1:0]     TGD_ToTarget;
    logic                    LOCK;
    logic                    STALL;
    logic                    ACK;
    logic                    ERR;
    logic [DataWidth-1:0]    DAT_ToInitiator;
    logic [TGDWidth-1:0]     TGD_ToInitiator;

    modport master (
        output CYC, STB, WE, ADDR, SEL, DAT_ToTarget, TGD_ToTarget, LOCK,
        input  STALL, ACK, ERR, DAT_ToInitiator, TGD_ToInitiator
    );

    modport slave (
        input  CYC, STB, WE, ADDR, SEL, DAT_ToTarget, TGD_ToTarget, LOCK,
        output STALL, ACK, ERR, DAT_ToInitiator, TGD_ToInitiator
    );

endinterface

// File: rtl/wishbone_response_pipe.sv
// Fixed-length delay line of responses with a per-stage valid bit; flush kills
// every in-flight entry at once.
module wishbone_response_pipe #(
    parameter int unsigned Depth  = 1,
    parameter type         resp_t = logic
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  in_valid,
    input  resp_t in_data,
    output logic  out_valid,
    output resp_t out_data
);
    logic [Depth-1:0] valid_q;
    resp_t            data_q [Depth];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < Depth; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // Payload needs no reset: it is only looked at when its valid bit is set.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int k = 1; k < Depth; k++) begin
            data_q[k] <= data_q[k-1];
        end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_data  = data_q[Depth-1];

endmodule

// File: rtl/wishbone_sram_target.sv
// Wishbone B4 pipelined target over a byte-lane SRAM: in-order fixed-latency
// responses, ERR for words beyond MemDepth, optional zero sweep after reset.
module wishbone_sram_target
    import wishbone_pkg::*;
#(
    parameter int unsigned AddressWidth = 16,
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned Granularity  = 8,
    parameter int unsigned TGDWidth     = 1,
    parameter int unsigned MemDepth     = 1024,
    parameter int unsigned ReadLatency  = 1,
    parameter int unsigned ClearOnReset = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    wishbone_sram_target_if.slave  bus,
    output logic                   Busy
);
    localparam int unsigned SelWidth = sel_width(DataWidth, Granularity);
    localparam int unsigned IdxWidth = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam logic [IdxWidth-1:0]     LastIdx    = IdxWidth'(MemDepth - 1);
    localparam logic [AddressWidth:0]   DepthLimit = (AddressWidth + 1)'(MemDepth);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    typedef struct packed {
        logic                 err;
        logic                 we;
        logic [TGDWidth-1:0]  tgd;
        logic [DataWidth-1:0] dat;
    } resp_t;

    state_e               state_q;
    logic [IdxWidth-1:0]  clr_idx_q;
    logic                 stall_q;
    logic                 busy_q;
    logic [DataWidth-1:0] mem [MemDepth];

    logic                 in_range;
    logic                 accept;
    logic [IdxWidth-1:0]  req_idx;
    logic [DataWidth-1:0] mem_rdata;
    logic                 mem_we;
    logic [IdxWidth-1:0]  mem_idx;
    logic [DataWidth-1:0] mem_wdata;
    logic [SelWidth-1:0]  mem_lanes;
    resp_t                resp_in;
    resp_t                resp_out;
    logic                 resp_valid;
    logic                 unused_lock;
    logic                 unused_we;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= (ClearOnReset != 0) ? StClear : StReady;
            clr_idx_q <= '0;
            stall_q   <= 1'b1;
            busy_q    <= (ClearOnReset != 0);
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LastIdx) begin
                        state_q <= StReady;
                        stall_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                StReady: begin
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StReady;
            endcase
        end
    end

    assign in_range  = ({1'b0, bus.ADDR} < DepthLimit);
    assign accept    = bus.CYC & bus.STB & ~stall_q & ~RST;
    assign req_idx   = bus.ADDR[IdxWidth-1:0];
    // Asynchronous read so a read right after a write to the same word sees new data.
    assign mem_rdata = mem[req_idx];

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_wdata = bus.DAT_ToTarget;
        mem_lanes = bus.SEL;
        if (state_q == StClear && !RST) begin
            mem_we    = 1'b1;
            mem_idx   = clr_idx_q;
            mem_wdata = '0;
            mem_lanes = '1;
        end else if (accept && bus.WE && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int k = 0; k < SelWidth; k++) begin
                if (mem_lanes[k]) begin
                    mem[mem_idx][k*Granularity +: Granularity] <=
                        mem_wdata[k*Granularity +: Granularity];
                end
            end
        end
    end

    always_comb begin
        resp_in.err = ~in_range;
        resp_in.we  = bus.WE;
        resp_in.tgd = bus.TGD_ToTarget;
        resp_in.dat = (in_range && !bus.WE) ? mem_rdata : '0;
    end

    wishbone_response_pipe #(
        .Depth  (ReadLatency),
        .resp_t (resp_t)
    ) u_resp_pipe (
        .clk       (CLK),
        .rst       (RST),
        .flush     (~bus.CYC),
        .in_valid  (accept),
        .in_data   (resp_in),
        .out_valid (resp_valid),
        .out_data  (resp_out)
    );

    assign bus.STALL           = stall_q;
    assign bus.ACK             = resp_valid & ~resp_out.err;
    assign bus.ERR             = resp_valid & resp_out.err;
    assign bus.DAT_ToInitiator = resp_valid ? resp_out.dat : '0;
    assign bus.TGD_ToInitiator = resp_valid ? resp_out.tgd : '0;
    assign Busy                = busy_q;

    assign unused_lock = bus.LOCK;
    assign unused_we   = resp_out.we;

endmodule

// File: tb/tb_wishbone_sram_target.sv
// Bench for wishbone_sram_target: directed and random traffic against a
// transaction-level memory model with a queue of expected terminations.
module tb_wishbone_sram_target;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MD = 16;
    localparam int RL = 2;

    logic CLK = 1'b0;
    logic RST;
    logic busy;

    always #5 CLK = ~CLK;

    wishbone_sram_target_if #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .Granularity  (8),
        .TGDWidth     (1)
    ) bus ();

    wishbone_sram_target #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .Granularity  (8),
        .TGDWidth     (1),
        .MemDepth     (MD),
        .ReadLatency  (RL),
        .ClearOnReset (1)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .Busy (busy)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] dat;
        logic        tgd;
    } exp_t;

    logic [31:0] ref_mem [MD];
    exp_t        pend [$];
    int          cyc;
    int          ready_cyc;
    int          total;
    int          bad;
    int          ack_count;
    int          snap;
    logic [31:0] last_dat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Check this cycle's outputs, update the model with this cycle's request, advance.
    task automatic tick();
        exp_t        e;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic        exp_tgd;
        logic        exp_stall;
        logic [31:0] w;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dat = '0;
        exp_tgd = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            exp_err = e.err;
            exp_ack = !e.err;
            exp_dat = e.dat;
            exp_tgd = e.tgd;
        end
        exp_stall = (cyc < ready_cyc);
        check("stall", 64'(bus.STALL), 64'(exp_stall));
        check("busy", 64'(busy), 64'(exp_stall));
        check("ack", 64'(bus.ACK), 64'(exp_ack));
        check("err", 64'(bus.ERR), 64'(exp_err));
        check("dat", 64'(bus.DAT_ToInitiator), 64'(exp_dat));
        check("tgd", 64'(bus.TGD_ToInitiator), 64'(exp_tgd));
        if (bus.ACK) begin
            last_dat = bus.DAT_ToInitiator;
            ack_count++;
        end
        if (!bus.CYC) begin
            pend.delete();
        end else if (bus.STB && !exp_stall) begin
            e.due = cyc + RL;
            e.tgd = bus.TGD_ToTarget;
            e.err = (int'(bus.ADDR) >= MD);
            e.dat = '0;
            if (!e.err) begin
                if (bus.WE) begin
                    w = ref_mem[int'(bus.ADDR)];
                    for (int k = 0; k < SW; k++) begin
                        if (bus.SEL[k]) w[k*8 +: 8] = bus.DAT_ToTarget[k*8 +: 8];
                    end
                    ref_mem[int'(bus.ADDR)] = w;
                end else begin
                    e.dat = ref_mem[int'(bus.ADDR)];
                end
            end
            pend.push_back(e);
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic req(input logic c, input logic s, input logic we, input int a,
                       input logic [3:0] sel, input logic [31:0] d, input logic t);
        bus.CYC          = c;
        bus.STB          = s;
        bus.WE           = we;
        bus.ADDR         = AW'(a);
        bus.SEL          = sel;
        bus.DAT_ToTarget = d;
        bus.TGD_ToTarget = t;
        bus.LOCK         = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b1, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        RST     = 1'b1;
        bus.CYC = 1'b0;
        bus.STB = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            check("rst_stall", 64'(bus.STALL), 64'd1);
            check("rst_busy", 64'(busy), 64'd1);
            check("rst_ack", 64'(bus.ACK), 64'd0);
            check("rst_err", 64'(bus.ERR), 64'd0);
            check("rst_dat", 64'(bus.DAT_ToInitiator), 64'd0);
            check("rst_tgd", 64'(bus.TGD_ToInitiator), 64'd0);
        end
        RST       = 1'b0;
        cyc       = 0;
        ready_cyc = MD;
        pend.delete();
        for (int i = 0; i < MD; i++) ref_mem[i] = '0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ack_count = 0;
        last_dat  = '0;
        bus.WE = 1'b0; bus.ADDR = '0; bus.SEL = '0; bus.DAT_ToTarget = '0;
        bus.TGD_ToTarget = '0; bus.LOCK = 1'b0;
        do_reset(3);

        // Requests offered during the sweep must be ignored.
        for (int i = 0; i < MD; i++) req(1'b1, 1'b1, 1'b0, 5, 4'hF, 32'h0, 1'b1);
        req(1'b1, 1'b1, 1'b0, 5, 4'hF, 32'h0, 1'b0);
        last_dat = 32'hDEAD_BEEF;
        idle(3);
        check("sweep_word5", 64'(last_dat), 64'h0);

        req(1'b1, 1'b1, 1'b1, 3, 4'hF, 32'h0000_00A5, 1'b0);
        req(1'b1, 1'b1, 1'b0, 3, 4'hF, 32'h0, 1'b1);
        idle(3);
        check("raw_word3", 64'(last_dat), 64'hA5);

        req(1'b1, 1'b1, 1'b1, 9, 4'hF, 32'hFFFF_FFFF, 1'b0);
        req(1'b1, 1'b1, 1'b1, 9, 4'b0101, 32'h1122_3344, 1'b0);
        req(1'b1, 1'b1, 1'b0, 9, 4'h0, 32'h0, 1'b0);
        idle(3);
        check("lanes_word9", 64'(last_dat), 64'hFF22_FF44);

        req(1'b1, 1'b1, 1'b1, 9, 4'h0, 32'h0, 1'b1);
        req(1'b1, 1'b1, 1'b0, 9, 4'h0, 32'h0, 1'b0);
        idle(3);
        check("sel0_keep", 64'(last_dat), 64'hFF22_FF44);

        req(1'b1, 1'b1, 1'b0, MD, 4'hF, 32'h0, 1'b1);
        req(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 32'h1234_5678, 1'b0);
        idle(3);

        for (int i = 0; i < 4; i++) req(1'b1, 1'b1, 1'b0, i, 4'hF, 32'h0, i[0]);
        req(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        snap = ack_count;
        idle(4);
        check("no_ack_after_drop", 64'(ack_count - snap), 64'd0);

        for (int i = 0; i < 400; i++) begin
            bus.LOCK = 1'($urandom);
            req(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, MD + 3)), 4'($urandom), $urandom, 1'($urandom));
        end
        idle(3);

        // A read in flight when reset hits must never terminate.
        req(1'b1, 1'b1, 1'b0, 3, 4'hF, 32'h0, 1'b1);
        do_reset(2);
        idle(7);
        do_reset(1);
        idle(MD);
        for (int i = 0; i < MD; i++) req(1'b1, 1'b1, 1'b0, i, 4'hF, 32'h0, i[1]);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
